// File: rtl/mfu_pkg.sv
// rtl/mfu_pkg.sv - shared button indices, compute opcodes and press arbitration helper
package mfu_pkg;

   localparam int NUM_BTN     = 5;

   localparam int BTN_NUM1    = 0;
   localparam int BTN_NUM2    = 1;
   localparam int BTN_COMPUTE = 2;
   localparam int BTN_DISPLAY = 3;
   localparam int BTN_RESET   = 4;

   typedef logic [NUM_BTN-1:0] btn_vec_t;

   // Opcodes decoded by the downstream compute block from input_bus.
   typedef enum logic [2:0] {
      OP_ADD = 3'b000,
      OP_SUB = 3'b001,
      OP_AND = 3'b010,
      OP_OR  = 3'b011,
      OP_XOR = 3'b100,
      OP_SHL = 3'b101,
      OP_SHR = 3'b110
   } op_e;

   // Fixed-priority pick among simultaneous press events:
   // reset > num1 > num2 > compute > display. Losers are simply dropped.
   function automatic btn_vec_t pick_winner(input btn_vec_t req);
      btn_vec_t win;
      win = '0;
      if (req[BTN_RESET])
         win[BTN_RESET] = 1'b1;
      else if (req[BTN_NUM1])
         win[BTN_NUM1] = 1'b1;
      else if (req[BTN_NUM2])
         win[BTN_NUM2] = 1'b1;
      else if (req[BTN_COMPUTE])
         win[BTN_COMPUTE] = 1'b1;
      else if (req[BTN_DISPLAY])
         win[BTN_DISPLAY] = 1'b1;
      return win;
   endfunction

endpackage

// File: rtl/mfu_debouncer.sv
// rtl/mfu_debouncer.sv - synchronise, debounce and edge-detect one push-button
module mfu_debouncer #(
   parameter int DEBOUNCE_CYCLES = 1_000_000
) (
   input  logic clock,
   input  logic reset_n,
   input  logic raw,
   output logic level,
   output logic rise
);

   localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync;
   logic             stable;
   logic             stable_q;
   logic [CNT_W-1:0] cnt;

   mfu_sync #(.W(1)) u_sync (
      .clock   (clock),
      .reset_n (reset_n),
      .d       (raw),
      .q       (sync)
   );

   // Flip the stable level only after DEBOUNCE_CYCLES consecutive disagreeing
   // samples; any agreeing sample restarts the count, so short glitches vanish.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         stable <= 1'b0;
         cnt    <= '0;
      end else if (sync == stable) begin
         cnt    <= '0;
      end else if (cnt == CNT_LAST) begin
         stable <= sync;
         cnt    <= '0;
      end else begin
         cnt    <= cnt + CNT_W'(1);
      end
   end

   // Delayed copy of the stable level, used to find the 0->1 press edge.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)
         stable_q <= 1'b0;
      else
         stable_q <= stable;
   end

   assign level = stable;
   assign rise  = stable & ~stable_q;

endmodule

// File: rtl/mfu_sync.sv
// rtl/mfu_sync.sv - two-flop synchroniser for asynchronous inputs
module mfu_sync #(
   parameter int W = 1
) (
   input  logic         clock,
   input  logic         reset_n,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   logic [W-1:0] meta;

   // First flop may go metastable; second flop gives a full cycle to settle.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         meta <= '0;
         q    <= '0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/mfu_input_conditioner.sv
// rtl/mfu_input_conditioner.sv - button/switch front end producing one-hot command pulses
module mfu_input_conditioner
   import mfu_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 1_000_000
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic [7:0] sw_raw,
   input  logic       btn_num1_raw,
   input  logic       btn_num2_raw,
   input  logic       btn_compute_raw,
   input  logic       btn_display_raw,
   input  logic       btn_reset_raw,
   output logic [7:0] input_bus,
   output logic       mode_input_num1,
   output logic       mode_input_num2,
   output logic       mode_compute,
   output logic       mode_display,
   output logic       mode_reset,
   output logic [4:0] btn_level
);

   btn_vec_t   raw_vec;
   btn_vec_t   level_vec;
   btn_vec_t   rise_vec;
   btn_vec_t   winner;
   btn_vec_t   pulse_q;
   logic [7:0] sw_sync;

   assign raw_vec[BTN_NUM1]    = btn_num1_raw;
   assign raw_vec[BTN_NUM2]    = btn_num2_raw;
   assign raw_vec[BTN_COMPUTE] = btn_compute_raw;
   assign raw_vec[BTN_DISPLAY] = btn_display_raw;
   assign raw_vec[BTN_RESET]   = btn_reset_raw;

   for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
      mfu_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
         .clock   (clock),
         .reset_n (reset_n),
         .raw     (raw_vec[i]),
         .level   (level_vec[i]),
         .rise    (rise_vec[i])
      );
   end

   // Switches only need synchronising; they are sampled at pulse time anyway.
   mfu_sync #(.W(8)) u_sw_sync (
      .clock   (clock),
      .reset_n (reset_n),
      .d       (sw_raw),
      .q       (sw_sync)
   );

   // Select a single winner among press events arriving in the same cycle.
   always_comb begin
      winner = pick_winner(rise_vec);
   end

   // Register the winner so each command is a clean one-cycle pulse.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)
         pulse_q <= '0;
      else
         pulse_q <= winner;
   end

   // Capture switches alongside the pulse; a reset command clears the bus instead.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)
         input_bus <= 8'h00;
      else if (winner[BTN_RESET])
         input_bus <= 8'h00;
      else if (|winner)
         input_bus <= sw_sync;
   end

   assign mode_input_num1 = pulse_q[BTN_NUM1];
   assign mode_input_num2 = pulse_q[BTN_NUM2];
   assign mode_compute    = pulse_q[BTN_COMPUTE];
   assign mode_display    = pulse_q[BTN_DISPLAY];
   assign mode_reset      = pulse_q[BTN_RESET];
   assign btn_level       = level_vec;

endmodule

// File: tb/tb_mfu_input_conditioner.sv
// tb/tb_mfu_input_conditioner.sv - directed and random checks against a window-based reference model
module tb_mfu_input_conditioner;

   localparam int D    = 4;
   localparam int HMAX = 8192;

   logic       clock = 1'b0;
   logic       reset_n;
   logic [7:0] sw_raw;
   logic [4:0] btn_raw;
   logic [7:0] input_bus;
   logic       mode_input_num1, mode_input_num2, mode_compute, mode_display, mode_reset;
   logic [4:0] btn_level;

   mfu_input_conditioner #(.DEBOUNCE_CYCLES(D)) dut (
      .clock           (clock),
      .reset_n         (reset_n),
      .sw_raw          (sw_raw),
      .btn_num1_raw    (btn_raw[0]),
      .btn_num2_raw    (btn_raw[1]),
      .btn_compute_raw (btn_raw[2]),
      .btn_display_raw (btn_raw[3]),
      .btn_reset_raw   (btn_raw[4]),
      .input_bus       (input_bus),
      .mode_input_num1 (mode_input_num1),
      .mode_input_num2 (mode_input_num2),
      .mode_compute    (mode_compute),
      .mode_display    (mode_display),
      .mode_reset      (mode_reset),
      .btn_level       (btn_level)
   );

   always #5 clock = ~clock;

   wire [4:0] dut_pulse = {mode_reset, mode_display, mode_compute, mode_input_num2, mode_input_num1};

   int         checks = 0;
   int         errors = 0;
   int         n = 0;
   int         rst_mark = 0;
   logic [4:0] hist_btn [HMAX];
   logic [7:0] hist_sw  [HMAX];
   logic [4:0] m_stable, m_rise, m_pulse;
   logic [7:0] m_bus;
   int         pcnt [5];
   int         plast [5];
   int         hold [5];
   int         e0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Button vector the debouncer sees at edge k: raw sampled two edges earlier, zero across reset.
   function automatic logic [4:0] seen_btn(int k);
      return (k - 2 > rst_mark) ? hist_btn[(k - 2) % HMAX] : 5'b0;
   endfunction

   function automatic logic [7:0] seen_sw(int k);
      return (k - 2 > rst_mark) ? hist_sw[(k - 2) % HMAX] : 8'h00;
   endfunction

   function automatic logic [4:0] arbitrate(logic [4:0] req);
      int order [5] = '{4, 0, 1, 2, 3};
      logic [4:0] w = 5'b0;
      for (int i = 0; i < 5; i++)
         if (req[order[i]]) begin
            w[order[i]] = 1'b1;
            return w;
         end
      return w;
   endfunction

   task automatic clear_counts();
      for (int b = 0; b < 5; b++) begin
         pcnt[b]  = 0;
         plast[b] = -1;
      end
   endtask

   // One clock edge: record inputs, advance the model, compare all outputs.
   task automatic tick();
      logic [4:0] s;
      logic [4:0] nxt_rise;
      logic       all_diff;
      @(posedge clock);
      n++;
      hist_btn[n % HMAX] = btn_raw;
      hist_sw[n % HMAX]  = sw_raw;
      m_pulse = arbitrate(m_rise);
      if (m_pulse[4])
         m_bus = 8'h00;
      else if (m_pulse != 5'b0)
         m_bus = seen_sw(n);
      nxt_rise = 5'b0;
      for (int b = 0; b < 5; b++) begin
         all_diff = 1'b1;
         for (int j = 0; j < D; j++) begin
            s = seen_btn(n - j);
            if (s[b] == m_stable[b]) all_diff = 1'b0;
         end
         if (all_diff) begin
            nxt_rise[b] = ~m_stable[b];
            m_stable[b] = ~m_stable[b];
         end
      end
      m_rise = nxt_rise;
      #1;
      chk("pulse", 32'(dut_pulse), 32'(m_pulse));
      chk("input_bus", 32'(input_bus), 32'(m_bus));
      chk("btn_level", 32'(btn_level), 32'(m_stable));
      for (int b = 0; b < 5; b++)
         if (dut_pulse[b]) begin
            pcnt[b]++;
            plast[b] = n;
         end
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      #1;
      chk("rst_pulse", 32'(dut_pulse), 32'h0);
      chk("rst_bus", 32'(input_bus), 32'h0);
      chk("rst_level", 32'(btn_level), 32'h0);
      repeat (2) @(posedge clock);
      @(negedge clock);
      reset_n  = 1'b1;
      rst_mark = n;
      m_stable = 5'b0;
      m_rise   = 5'b0;
      m_pulse  = 5'b0;
      m_bus    = 8'h00;
   endtask

   task automatic press(input int b, input int hi, input int lo);
      btn_raw[b] = 1'b1;
      repeat (hi) tick();
      btn_raw[b] = 1'b0;
      repeat (lo) tick();
   endtask

   initial begin
      btn_raw = 5'b0;
      sw_raw  = 8'h00;
      clear_counts();
      #2;
      do_reset();

      // Single press with hold: one pulse at E6, bus captures 5A.
      clear_counts();
      sw_raw = 8'h5A;
      btn_raw[0] = 1'b1;
      e0 = n + 1;
      repeat (20) tick();
      chk("t1_num1_count", 32'(pcnt[0]), 32'd1);
      chk("t1_num1_edge", 32'(plast[0] - e0), 32'd6);
      chk("t1_bus", 32'(input_bus), 32'h5A);
      btn_raw[0] = 1'b0;
      repeat (12) tick();

      // Bouncing compute button never holds long enough.
      clear_counts();
      repeat (10) begin
         btn_raw[2] = 1'b1;
         repeat (3) tick();
         btn_raw[2] = 1'b0;
         tick();
      end
      repeat (10) tick();
      chk("t2_compute_count", 32'(pcnt[2]), 32'd0);

      // Simultaneous num2/display: num2 wins, display needs a fresh press.
      clear_counts();
      btn_raw[1] = 1'b1;
      btn_raw[3] = 1'b1;
      repeat (14) tick();
      chk("t3_num2_count", 32'(pcnt[1]), 32'd1);
      chk("t3_display_count", 32'(pcnt[3]), 32'd0);
      btn_raw[1] = 1'b0;
      btn_raw[3] = 1'b0;
      repeat (12) tick();
      press(3, 12, 12);
      chk("t3_display_repress", 32'(pcnt[3]), 32'd1);

      // Bus holds across switch motion until the next pulse.
      sw_raw = 8'h0F;
      press(3, 10, 10);
      chk("t4_bus_after_display", 32'(input_bus), 32'h0F);
      sw_raw = 8'hF0;
      repeat (8) tick();
      chk("t4_bus_held", 32'(input_bus), 32'h0F);
      btn_raw[2] = 1'b1;
      repeat (6) tick();
      chk("t4_bus_before_pulse", 32'(input_bus), 32'h0F);
      tick();
      chk("t4_compute_pulse", 32'(mode_compute), 32'd1);
      chk("t4_bus_at_pulse", 32'(input_bus), 32'hF0);
      btn_raw[2] = 1'b0;
      repeat (12) tick();

      // Reset command clears the bus.
      sw_raw = 8'h33;
      press(0, 10, 10);
      chk("t5_bus_33", 32'(input_bus), 32'h33);
      sw_raw = 8'hAA;
      clear_counts();
      btn_raw[4] = 1'b1;
      repeat (6) tick();
      chk("t5_bus_before", 32'(input_bus), 32'h33);
      tick();
      chk("t5_reset_pulse", 32'(mode_reset), 32'd1);
      chk("t5_bus_cleared", 32'(input_bus), 32'h00);
      repeat (10) tick();
      chk("t5_reset_count", 32'(pcnt[4]), 32'd1);
      btn_raw[4] = 1'b0;
      repeat (12) tick();

      // Reset mid-count: partial count discarded, held button re-debounced.
      sw_raw = 8'hC3;
      press(0, 10, 10);
      chk("t6_bus_c3", 32'(input_bus), 32'hC3);
      btn_raw[1] = 1'b1;
      repeat (4) tick();
      do_reset();
      clear_counts();
      e0 = n + 1;
      repeat (12) tick();
      chk("t6_num2_count", 32'(pcnt[1]), 32'd1);
      chk("t6_num2_edge", 32'(plast[1] - e0), 32'd6);
      btn_raw[1] = 1'b0;
      repeat (12) tick();

      // Random bouncing on all buttons and switches.
      for (int b = 0; b < 5; b++) hold[b] = 1;
      for (int t = 0; t < 1500; t++) begin
         for (int b = 0; b < 5; b++) begin
            hold[b]--;
            if (hold[b] <= 0) begin
               btn_raw[b] = $urandom_range(0, 1) != 0;
               hold[b]    = $urandom_range(1, 10);
            end
         end
         if ($urandom_range(0, 7) == 0) sw_raw = 8'($urandom);
         if (t == 750) do_reset();
         tick();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
